// File: rtl/vedic_seq_mul_ctrl.sv
// rtl/vedic_seq_mul_ctrl.sv - sequential WIDTHxWIDTH multiplier built on one shared vedic 2x2 core

// 2x2 vedic multiplier: 2-bit x 2-bit unsigned product, purely combinational.
module vedic_2x2 (
  input  logic [1:0] mul_1,
  input  logic [1:0] mul_2,
  output logic [3:0] product
);
  logic p_cross;
  logic c_cross;
  logic p_high;

  // Vertically-and-crosswise: low bit, cross terms, then the high digit plus carry.
  always_comb begin
    p_cross    = (mul_1[1] & mul_2[0]) ^ (mul_1[0] & mul_2[1]);
    c_cross    = (mul_1[1] & mul_2[0]) & (mul_1[0] & mul_2[1]);
    p_high     = mul_1[1] & mul_2[1];
    product[0] = mul_1[0] & mul_2[0];
    product[1] = p_cross;
    product[2] = p_high ^ c_cross;
    product[3] = p_high & c_cross;
  end
endmodule

// Controller: accepts an operand pair, walks every (i, j) digit pair through the
// shared core, accumulates shifted partial products, then holds the result.
module vedic_seq_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N    = WIDTH / 2;
  localparam int I_W  = (N > 1) ? $clog2(N) : 1;
  localparam int P_W  = 2 * WIDTH;
  localparam int SH_W = $clog2(P_W);
  localparam logic [I_W-1:0] LAST = I_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   acc_next;
  logic [P_W-1:0]   term;
  logic [I_W-1:0]   i_idx;
  logic [I_W-1:0]   j_idx;
  logic [1:0]       mul_1;
  logic [1:0]       mul_2;
  logic [3:0]       core_product;
  logic [SH_W-1:0]  shift_amt;
  logic             last_step;

  // The step counter k is kept split as (i, j) so no divider is needed for k/N, k%N.
  always_comb begin
    mul_1     = 2'(a_reg >> {i_idx, 1'b0});
    mul_2     = 2'(b_reg >> {j_idx, 1'b0});
    shift_amt = SH_W'({i_idx, 1'b0}) + SH_W'({j_idx, 1'b0});
    term      = P_W'(core_product) << shift_amt;
    acc_next  = acc + term;
    last_step = (i_idx == LAST) && (j_idx == LAST);
  end

  vedic_2x2 u_core (
    .mul_1   (mul_1),
    .mul_2   (mul_2),
    .product (core_product)
  );

  // Handshake flags are pure decodes of the state register.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // Sequencer: accept, accumulate one partial product per cycle, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last_step) begin
            i_idx   <= '0;
            j_idx   <= '0;
            product <= acc_next;
            state   <= HOLD;
          end else if (j_idx == LAST) begin
            j_idx <= '0;
            i_idx <= i_idx + I_W'(1);
          end else begin
            j_idx <= j_idx + I_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
